// File: rtl/int_sched_if.sv
// int_sched_if: register bus, interrupt sources and core handshake for int_sched
interface int_sched_if #(parameter int NUM_SRC = 4, parameter int INT_W = 8);
  logic [NUM_SRC-1:0] src_i;
  logic               we_i;
  logic [1:0]         addr_i;
  logic [31:0]        wdata_i;
  logic [31:0]        rdata_o;
  logic [INT_W-1:0]   int_flag_o;
  logic               int_ack_i;
  logic               busy_o;
  modport master (output src_i, we_i, addr_i, wdata_i, int_ack_i, input rdata_o, int_flag_o, busy_o);
  modport slave (input src_i, we_i, addr_i, wdata_i, int_ack_i, output rdata_o, int_flag_o, busy_o);
endinterface

// File: rtl/int_sched.sv
// int_sched: edge-latched interrupt scheduler, lowest index wins, single request in flight
module int_sched #(
  parameter int NUM_SRC = 4,
  parameter int INT_W = 8
) (
  input logic clk,
  input logic rst,
  int_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, IN_SERVICE} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] src_q, pending_q, pending_d, enable_q, enable_d, insvc_q, insvc_d;
  logic [NUM_SRC-1:0] edge_det, elig, cur_mask, ack_clr, w1c;
  logic [2:0] cur_id_q, cur_id_d, win;
  logic [INT_W-1:0] flag_q, flag_d;
  logic complete_hit;
  always_comb begin
    edge_det = bus.src_i & ~src_q;
    elig = pending_q & enable_q & ~insvc_q;
    win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) win = elig[k] ? 3'(k + 1) : win;
    cur_mask = (cur_id_q == 3'd0) ? '0 : NUM_SRC'(1) << (cur_id_q - 3'd1);
    w1c = (bus.we_i && bus.addr_i == 2'd1) ? bus.wdata_i[NUM_SRC-1:0] : '0;
    enable_d = (bus.we_i && bus.addr_i == 2'd0) ? bus.wdata_i[NUM_SRC-1:0] : enable_q;
    complete_hit = bus.we_i && bus.addr_i == 2'd3 && bus.wdata_i[2:0] == cur_id_q;
    state_d = state_q;
    cur_id_d = cur_id_q;
    insvc_d = insvc_q;
    flag_d = '0;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        cur_id_d = (win != 3'd0) ? win : cur_id_q;
        state_d = (win != 3'd0) ? ASSERT : IDLE;
      end
      ASSERT: begin
        flag_d = INT_W'(cur_id_q);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // a source disabled mid-request is withdrawn but stays pending for later
        if ((enable_q & cur_mask) == '0) begin
          state_d = IDLE;
          cur_id_d = '0;
        end else if (bus.int_ack_i) begin
          ack_clr = cur_mask;
          insvc_d = insvc_q | cur_mask;
          state_d = IN_SERVICE;
        end else begin
          flag_d = INT_W'(cur_id_q);
        end
      end
      IN_SERVICE: begin
        if (complete_hit) begin
          insvc_d = insvc_q & ~cur_mask;
          cur_id_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a fresh edge overrides any clear in the same cycle
    pending_d = (pending_q & ~(w1c | ack_clr)) | edge_det;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q <= '0;
      pending_q <= '0;
      enable_q <= '0;
      insvc_q <= '0;
      cur_id_q <= '0;
      flag_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= bus.src_i;
      pending_q <= pending_d;
      enable_q <= enable_d;
      insvc_q <= insvc_d;
      cur_id_q <= cur_id_d;
      flag_q <= flag_d;
    end
  end
  always_comb begin
    bus.int_flag_o = flag_q;
    bus.busy_o = state_q != IDLE;
    bus.rdata_o = (bus.addr_i == 2'd0) ? 32'(enable_q) :
                  (bus.addr_i == 2'd1) ? 32'(pending_q) :
                  (bus.addr_i == 2'd2 && state_q != IDLE) ? 32'(cur_id_q) : 32'd0;
  end
endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed vectors against hand-computed expectations for int_sched
module tb_int_sched;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_pass = 0;
  int_sched_if #(.NUM_SRC(4), .INT_W(8)) bus ();
  int_sched #(.NUM_SRC(4), .INT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we_i = 1;
    bus.addr_i = a;
    bus.wdata_i = d;
    tick();
    bus.we_i = 0;
    bus.wdata_i = 0;
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr_i = a;
    #1;
    check(tag, bus.rdata_o, exp);
  endtask
  task automatic ack();
    bus.int_ack_i = 1;
    tick();
    bus.int_ack_i = 0;
  endtask
  initial begin
    bus.src_i = 0;
    bus.we_i = 0;
    bus.addr_i = 0;
    bus.wdata_i = 0;
    bus.int_ack_i = 0;
    tick();
    tick();
    check("rst_flag", 32'(bus.int_flag_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    rst = 0;
    rd("rst_enable", 0, 0);
    rd("rst_pending", 1, 0);
    // single source, full handshake
    wr(0, 32'hF);
    rd("enable_f", 0, 32'hF);
    bus.src_i = 4'b0100;
    tick();
    check("s1_flag_e0", 32'(bus.int_flag_o), 0);
    tick();
    check("s1_flag_e1", 32'(bus.int_flag_o), 0);
    check("s1_busy_e1", 32'(bus.busy_o), 1);
    tick();
    check("s1_flag_lat2", 32'(bus.int_flag_o), 3);
    tick();
    check("s1_flag_hold", 32'(bus.int_flag_o), 3);
    rd("s1_pend_pre", 1, 32'h4);
    ack();
    check("s1_flag_acked", 32'(bus.int_flag_o), 0);
    rd("s1_pend_post", 1, 0);
    rd("s1_claim", 2, 3);
    bus.src_i = 0;
    ack();
    check("s1_stray_ack", 32'(bus.busy_o), 1);
    rd("s1_claim_again", 2, 3);
    wr(3, 3);
    check("s1_done_busy", 32'(bus.busy_o), 0);
    rd("s1_claim_idle", 2, 0);
    // two simultaneous sources: lowest index first, then the other without a new edge
    bus.src_i = 4'b1001;
    tick();
    tick();
    tick();
    check("s2_first", 32'(bus.int_flag_o), 1);
    bus.src_i = 0;
    ack();
    rd("s2_pend", 1, 32'h8);
    wr(3, 1);
    check("s2_idle", 32'(bus.busy_o), 0);
    tick();
    tick();
    check("s2_second", 32'(bus.int_flag_o), 4);
    rd("s2_claim", 2, 4);
    ack();
    wr(3, 4);
    check("s2_done", 32'(bus.busy_o), 0);
    // disabled source stays pending until enabled
    wr(0, 0);
    bus.src_i = 4'b0010;
    tick();
    tick();
    tick();
    rd("s3_pend", 1, 32'h2);
    check("s3_no_flag", 32'(bus.int_flag_o), 0);
    check("s3_idle", 32'(bus.busy_o), 0);
    bus.src_i = 0;
    wr(0, 2);
    tick();
    tick();
    check("s3_flag", 32'(bus.int_flag_o), 2);
    ack();
    wr(3, 1);
    check("s4_wrong_id", 32'(bus.busy_o), 1);
    rd("s4_claim", 2, 2);
    wr(3, 2);
    check("s4_right_id", 32'(bus.busy_o), 0);
    // disable while waiting for ack withdraws the request
    wr(0, 32'h1);
    bus.src_i = 4'b0001;
    tick();
    bus.src_i = 0;
    tick();
    tick();
    check("s5_flag", 32'(bus.int_flag_o), 1);
    wr(0, 0);
    tick();
    check("s5_dropped", 32'(bus.int_flag_o), 0);
    check("s5_idle", 32'(bus.busy_o), 0);
    rd("s5_pend_kept", 1, 32'h1);
    wr(1, 32'h1);
    rd("s5_w1c", 1, 0);
    // edge beats a same-cycle clear
    bus.src_i = 4'b0001;
    bus.we_i = 1;
    bus.addr_i = 1;
    bus.wdata_i = 1;
    tick();
    bus.we_i = 0;
    bus.src_i = 0;
    rd("s6_edge_wins", 1, 32'h1);
    wr(1, 32'h1);
    // reset mid-handshake
    wr(0, 32'h4);
    bus.src_i = 4'b0100;
    tick();
    tick();
    tick();
    check("s7_flag", 32'(bus.int_flag_o), 3);
    rst = 1;
    #1;
    check("s7_async_flag", 32'(bus.int_flag_o), 0);
    check("s7_async_busy", 32'(bus.busy_o), 0);
    bus.src_i = 0;
    tick();
    rst = 0;
    rd("s7_enable", 0, 0);
    rd("s7_pending", 1, 0);
    rd("s7_claim", 2, 0);
    rd("s7_complete", 3, 0);
    tick();
    tick();
    check("s7_quiet", 32'(bus.int_flag_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
